// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fetch_state_e;

  localparam int unsigned CountW = 32;

endpackage

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer for a 1-cycle-latency synchronous ROM: owns the PC,
// issues one ROM read per cycle and hands words to decode over valid/ready.
module rom_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned MEM_LENGHT  = 32,
  parameter bit          WRAP_EN     = 1'b0,
  localparam int unsigned ADDR_W     = $clog2(MEM_LENGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_LENGTH-1:0] rom_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  input  logic                   branch_valid,
  input  logic [ADDR_W-1:0]      branch_target,
  output logic                   done,
  output logic                   err,
  output logic [CountW-1:0]      instr_count
);

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(MEM_LENGHT - 1);

  fetch_state_e      state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CountW-1:0] cnt_q, cnt_d;

  logic accept;
  logic stall;
  logic tgt_oob;
  logic last_accept;

  // Without wrapping the PC parks on the last word instead of rolling over.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    if (pc == LastPc) begin
      return WRAP_EN ? '0 : LastPc;
    end
    return pc + ADDR_W'(1);
  endfunction

  assign accept      = resp_valid_q & out_ready;
  assign stall       = resp_valid_q & ~out_ready;
  assign tgt_oob     = 32'(branch_target) >= MEM_LENGHT;
  assign last_accept = accept & (resp_pc_q == LastPc) & ~WRAP_EN;

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    next_pc_d    = next_pc_q;
    done_d       = done_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    rom_addr     = '0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rom_addr     = '0;
          resp_valid_d = 1'b1;
          resp_pc_d    = '0;
          next_pc_d    = pc_inc('0);
          done_d       = 1'b0;
          err_d        = 1'b0;
          cnt_d        = '0;
          state_d      = StRun;
        end
      end
      StRun: begin
        if (accept && (cnt_q != '1)) begin
          cnt_d = cnt_q + CountW'(1);
        end
        if (branch_valid) begin
          if (tgt_oob) begin
            err_d        = 1'b1;
            done_d       = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = StDone;
          end else begin
            rom_addr     = branch_target;
            resp_pc_d    = branch_target;
            resp_valid_d = 1'b1;
            next_pc_d    = pc_inc(branch_target);
          end
        end else if (stall) begin
          // Re-read the held address so rom_data stays put across the stall.
          rom_addr = resp_pc_q;
        end else if (last_accept) begin
          resp_valid_d = 1'b0;
          done_d       = 1'b1;
          state_d      = StDone;
        end else begin
          rom_addr     = next_pc_q;
          resp_pc_d    = next_pc_q;
          resp_valid_d = 1'b1;
          next_pc_d    = pc_inc(next_pc_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      next_pc_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      next_pc_q    <= next_pc_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = resp_valid_q;
  assign out_pc      = resp_pc_q;
  assign out_instr   = rom_data;
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = cnt_q;

endmodule
